method_call_arbiter: RTL and testbench

- Shares one synthesized method instance among N requesters using the codebase's req/busy/return method protocol.
- Sits between the requesting units (or a test sequencer) and the shared method instance.
- Grants requesters round-robin, latches the selected argument, issues a one-cycle call request and tracks the callee's busy.
- Returns the result to the granted requester and enforces a cycle-count timeout.

---
 rtl/method_call_arbiter_if.sv | 32 +++
 rtl/method_call_arbiter.sv | 139 +++++++++++++
 tb/tb_method_call_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/method_call_arbiter_if.sv
// Requester-side and method-side signals of the shared-method arbiter.
interface method_call_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]    r_req;
  logic [N*AW-1:0] r_arg;
  logic [N-1:0]    r_busy;
  logic [N-1:0]    r_done;
  logic [N-1:0]    r_timeout;
  logic [DW-1:0]   r_return;
  logic            m_req;
  logic [AW-1:0]   m_arg;
  logic            m_busy;
  logic [DW-1:0]   m_return;
  logic [IW-1:0]   grant_id;

  // Arbiter side.
  modport master (
    input  r_req, r_arg, m_busy, m_return,
    output r_busy, r_done, r_timeout, r_return, m_req, m_arg, grant_id
  );

  // Requesters plus callee side.
  modport slave (
    output r_req, r_arg, m_busy, m_return,
    input  r_busy, r_done, r_timeout, r_return, m_req, m_arg, grant_id
  );
endinterface

// File: rtl/method_call_arbiter.sv
// Round-robin arbiter sharing one method instance (req/busy/return protocol) among N
// requesters, with a per-call cycle timeout.
module method_call_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic                   clk,
  input logic                   reset,
  method_call_arbiter_if.master bus
);
  localparam int unsigned IW = $clog2(N);
  // A disabled timeout still keeps a 1-bit counter so no zero-width vector appears.
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitDone, StResp} state_e;

  state_e        r_state, w_state_d;
  logic [IW-1:0] r_ptr, w_ptr_d;
  logic [IW-1:0] r_grant, w_grant_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic [N-1:0]  r_busy, w_busy_d;
  logic [N-1:0]  r_done, w_done_d;
  logic [N-1:0]  r_tmo, w_tmo_d;
  logic [DW-1:0] r_ret, w_ret_d;
  logic          r_mreq, w_mreq_d;
  logic [AW-1:0] r_marg, w_marg_d;

  logic          w_found;
  logic [IW-1:0] w_sel;
  logic [31:0]   w_cnt_inc;
  logic          w_cnt_hit;

  // Round-robin pick: first requester at or after the pointer, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && bus.r_req[IW'((32'(r_ptr) + i) % N)]) begin
        w_found = 1'b1;
        w_sel   = IW'((32'(r_ptr) + i) % N);
      end
    end
  end

  // Timeout fires when the count after this WAIT_DONE cycle reaches TIMEOUT.
  assign w_cnt_inc = 32'(r_cnt) + 32'd1;
  assign w_cnt_hit = (TIMEOUT != 0) && (w_cnt_inc >= TIMEOUT);

  // Next-state and next-output logic.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_grant_d = r_grant;
    w_cnt_d   = r_cnt;
    w_busy_d  = r_busy;
    w_done_d  = '0;
    w_tmo_d   = '0;
    w_ret_d   = r_ret;
    w_mreq_d  = 1'b0;
    w_marg_d  = r_marg;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_d        = w_sel;
          w_marg_d         = bus.r_arg[w_sel*AW +: AW];
          w_busy_d[w_sel]  = 1'b1;
          w_mreq_d         = 1'b1;  // registered, so m_req is high exactly during ISSUE
          w_state_d        = StIssue;
        end
      end
      StIssue: begin
        w_cnt_d   = '0;
        w_state_d = StWaitStart;
      end
      StWaitStart: begin
        w_state_d = StWaitDone;
      end
      StWaitDone: begin
        if (r_cnt != '1) begin
          w_cnt_d = r_cnt + CW'(1);
        end
        // Completion takes priority over a coincident timeout.
        if (!bus.m_busy) begin
          w_ret_d           = bus.m_return;
          w_done_d[r_grant] = 1'b1;
          w_state_d         = StResp;
        end else if (w_cnt_hit) begin
          w_tmo_d[r_grant]  = 1'b1;
          w_state_d         = StResp;
        end
      end
      StResp: begin
        w_busy_d[r_grant] = 1'b0;
        w_ptr_d           = (r_grant == IW'(N - 1)) ? '0 : r_grant + IW'(1);
        w_state_d         = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; async reset discards any in-flight call.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_busy  <= '0;
      r_done  <= '0;
      r_tmo   <= '0;
      r_ret   <= '0;
      r_mreq  <= 1'b0;
      r_marg  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_grant <= w_grant_d;
      r_cnt   <= w_cnt_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_tmo   <= w_tmo_d;
      r_ret   <= w_ret_d;
      r_mreq  <= w_mreq_d;
      r_marg  <= w_marg_d;
    end
  end

  assign bus.r_busy    = r_busy;
  assign bus.r_done    = r_done;
  assign bus.r_timeout = r_tmo;
  assign bus.r_return  = r_ret;
  assign bus.m_req     = r_mreq;
  assign bus.m_arg     = r_marg;
  assign bus.grant_id  = r_grant;
endmodule

// File: tb/tb_method_call_arbiter.sv
// Directed bench for method_call_arbiter: one instance with TIMEOUT=10, one with TIMEOUT=0.
module tb_method_call_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  method_call_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus_a ();
  method_call_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus_b ();

  method_call_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(10)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  method_call_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int checks   = 0;
  int failures = 0;
  int mreq_a   = 0;
  int done_a   = 0;
  int tmo_b    = 0;
  int done_b   = 0;

  logic [31:0] arg_tab [N] = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_1234, 32'h0000_00A3};

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_a.m_req)       mreq_a <= mreq_a + 1;
    if (|bus_a.r_done)     done_a <= done_a + 1;
    if (|bus_b.r_timeout)  tmo_b  <= tmo_b + 1;
    if (|bus_b.r_done)     done_b <= done_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_args();
    for (int i = 0; i < N; i++) bus_a.r_arg[i*AW +: AW] = arg_tab[i];
  endtask

  // One zero-wait call from IDLE: grant, ISSUE, WAIT_START, WAIT_DONE (done), RESP.
  task automatic serve(input int unsigned id, input logic [31:0] ret);
    tick(1);
    chk("grant_id", 64'(bus_a.grant_id), 64'(id));
    chk("m_req_issue", 64'(bus_a.m_req), 64'd1);
    chk("m_arg", 64'(bus_a.m_arg), 64'(arg_tab[id]));
    chk("r_busy_grant", 64'(bus_a.r_busy), 64'd1 << id);
    tick(2);
    bus_a.m_return = ret;
    tick(1);
    chk("r_done", 64'(bus_a.r_done), 64'd1 << id);
    chk("r_return", 64'(bus_a.r_return), 64'(ret));
    tick(1);
    chk("r_busy_clear", 64'(bus_a.r_busy), 64'd0);
  endtask

  initial begin
    int m0;
    reset          = 1'b0;
    bus_a.r_req    = '0;
    bus_a.r_arg    = '0;
    bus_a.m_busy   = 1'b0;
    bus_a.m_return = '0;
    bus_b.r_req    = '0;
    bus_b.r_arg    = '0;
    bus_b.m_busy   = 1'b0;
    bus_b.m_return = '0;
    drive_args();

    // Reset state.
    tick(2);
    chk("rst_r_busy", 64'(bus_a.r_busy), 64'd0);
    chk("rst_r_done", 64'(bus_a.r_done), 64'd0);
    chk("rst_r_timeout", 64'(bus_a.r_timeout), 64'd0);
    chk("rst_r_return", 64'(bus_a.r_return), 64'd0);
    chk("rst_m_req", 64'(bus_a.m_req), 64'd0);
    chk("rst_m_arg", 64'(bus_a.m_arg), 64'd0);
    chk("rst_grant_id", 64'(bus_a.grant_id), 64'd0);
    reset = 1'b1;

    // Single requester 2, callee busy for several cycles, returns 0xCAFE.
    bus_a.r_req = 4'b0100;
    tick(1);
    chk("s_m_req", 64'(bus_a.m_req), 64'd1);
    chk("s_m_arg", 64'(bus_a.m_arg), 64'h1234);
    chk("s_r_busy", 64'(bus_a.r_busy), 64'b0100);
    chk("s_grant", 64'(bus_a.grant_id), 64'd2);
    bus_a.m_busy = 1'b1;
    bus_a.r_arg[2*AW +: AW] = 32'h9999;  // must be ignored mid-call
    tick(1);
    chk("s_m_req_once", 64'(bus_a.m_req), 64'd0);
    tick(2);
    bus_a.r_req = '0;                    // dropped mid-call, call still completes
    tick(3);
    chk("s_done_early", 64'(bus_a.r_done), 64'd0);
    chk("s_busy_held", 64'(bus_a.r_busy), 64'b0100);
    bus_a.m_busy   = 1'b0;
    bus_a.m_return = 32'hCAFE;
    tick(1);
    chk("s_r_done", 64'(bus_a.r_done), 64'b0100);
    chk("s_r_return", 64'(bus_a.r_return), 64'hCAFE);
    chk("s_busy_at_done", 64'(bus_a.r_busy), 64'b0100);
    chk("s_no_timeout", 64'(bus_a.r_timeout), 64'd0);
    chk("s_m_arg_hold", 64'(bus_a.m_arg), 64'h1234);
    bus_a.m_return = 32'hDEAD;
    tick(1);
    chk("s_done_pulse", 64'(bus_a.r_done), 64'd0);
    chk("s_busy_fall", 64'(bus_a.r_busy), 64'd0);
    chk("s_return_kept", 64'(bus_a.r_return), 64'hCAFE);
    tick(1);
    chk("s_idle_no_req", 64'(bus_a.m_req), 64'd0);
    chk("s_mreq_count", 64'(mreq_a), 64'd1);
    chk("s_done_count", 64'(done_a), 64'd1);
    drive_args();

    // Wrap and skip: pointer is 3, only requester 1 asks; next pointer must be 2.
    bus_a.r_req = 4'b0010;
    serve(1, 32'h55);
    bus_a.r_req = 4'b1011;
    serve(3, 32'h66);

    // Round-robin fairness: pointer now 0, all requesting continuously.
    bus_a.r_req = 4'b1111;
    m0 = mreq_a;
    for (int k = 0; k < 8; k++) serve(k % 4, 32'h100 + k);
    chk("rr_mreq_count", 64'(mreq_a - m0), 64'd8);

    // Timeout with callee stuck busy; pointer 0, requester 3 only.
    bus_a.m_busy = 1'b1;
    bus_a.r_req  = 4'b1000;
    tick(1);
    chk("t_grant", 64'(bus_a.grant_id), 64'd3);
    tick(2);
    tick(9);
    chk("t_early", 64'(bus_a.r_timeout), 64'd0);
    tick(1);
    chk("t_pulse", 64'(bus_a.r_timeout), 64'b1000);
    chk("t_no_done", 64'(bus_a.r_done), 64'd0);
    chk("t_return_kept", 64'(bus_a.r_return), 64'h107);
    chk("t_busy", 64'(bus_a.r_busy), 64'b1000);
    bus_a.r_req = '0;
    tick(1);
    chk("t_pulse_end", 64'(bus_a.r_timeout), 64'd0);
    chk("t_busy_clear", 64'(bus_a.r_busy), 64'd0);
    bus_a.m_busy = 1'b0;                 // late fall of the abandoned call
    tick(2);
    chk("t_late_done", 64'(bus_a.r_done), 64'd0);
    chk("t_idle", 64'(bus_a.m_req), 64'd0);

    // Completion and timeout in the same cycle: completion wins.
    bus_a.m_busy = 1'b1;
    bus_a.r_req  = 4'b0001;
    tick(1);
    chk("c_grant", 64'(bus_a.grant_id), 64'd0);
    tick(11);
    bus_a.m_busy   = 1'b0;
    bus_a.m_return = 32'hBEEF;
    tick(1);
    chk("c_done", 64'(bus_a.r_done), 64'b0001);
    chk("c_no_timeout", 64'(bus_a.r_timeout), 64'd0);
    chk("c_return", 64'(bus_a.r_return), 64'hBEEF);
    bus_a.r_req = '0;
    tick(1);

    // Async reset in WAIT_DONE; pointer was 1 before the reset.
    bus_a.m_busy = 1'b1;
    bus_a.r_req  = 4'b0010;
    tick(4);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_r_busy", 64'(bus_a.r_busy), 64'd0);
    chk("ar_m_arg", 64'(bus_a.m_arg), 64'd0);
    chk("ar_grant", 64'(bus_a.grant_id), 64'd0);
    chk("ar_r_return", 64'(bus_a.r_return), 64'd0);
    chk("ar_m_req", 64'(bus_a.m_req), 64'd0);
    tick(1);
    reset        = 1'b1;
    bus_a.m_busy = 1'b0;
    bus_a.r_req  = 4'b0011;
    serve(0, 32'h77);
    bus_a.r_req = '0;
    tick(2);

    // TIMEOUT=0 instance: no timeout over 1000 busy cycles, then normal completion.
    bus_b.m_busy = 1'b1;
    bus_b.r_req  = 4'b0001;
    tick(1);
    chk("b_grant", 64'(bus_b.grant_id), 64'd0);
    tick(1000);
    chk("b_no_timeout", 64'(tmo_b), 64'd0);
    chk("b_no_done", 64'(done_b), 64'd0);
    chk("b_busy", 64'(bus_b.r_busy), 64'b0001);
    bus_b.m_busy   = 1'b0;
    bus_b.m_return = 32'h42;
    tick(1);
    chk("b_done", 64'(bus_b.r_done), 64'b0001);
    chk("b_return", 64'(bus_b.r_return), 64'h42);
    bus_b.r_req = '0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
